// File: rtl/podule_bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// podule_pkg
// Shared definitions for the podule bus controller and its tick timer:
//   - IOC cycle speed encodings (address bits [20:19])
//   - FSM state encodings
//   - slot count and tick counter width
//   - small helpers for slot decode and read-lane selection
// -----------------------------------------------------------------------------
package podule_pkg;

  localparam int SLOT_COUNT = 4;

  // Tick counter width. It saturates at the timeout limit (64), so 7 bits
  // always hold the count without wrapping.
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    SPD_SLOW = 2'd0,
    SPD_MED  = 2'd1,
    SPD_FAST = 2'd2,
    SPD_SYNC = 2'd3
  } speed_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    ACK     = 3'd4,
    RELEASE = 3'd5
  } state_e;

  // One-hot strobe for a slot number.
  function automatic logic [SLOT_COUNT-1:0] slot_onehot(input logic [1:0] slot);
    logic [SLOT_COUNT-1:0] oh;
    oh       = '0;
    oh[slot] = 1'b1;
    return oh;
  endfunction

  // Slot n drives its read data on bits [16n+15:16n] of the packed bus.
  function automatic logic [15:0] slot_lane(input logic [63:0] rdata,
                                            input logic [1:0]  slot);
    logic [15:0] lane;
    lane = rdata[15:0];
    case (slot)
      2'd0: lane = rdata[15:0];
      2'd1: lane = rdata[31:16];
      2'd2: lane = rdata[47:32];
      2'd3: lane = rdata[63:48];
      default: lane = rdata[15:0];
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/podule_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// podule_bus_ctrl_if
// CPU-side wishbone bundle for the podule bus controller.
//   master modport : CPU side (drives cyc/stb/we/adr/speed/dat_i)
//   slave modport  : controller side (drives dat_o/ack/err)
//
// Handshake: a request is presented by holding wb_cyc & wb_stb high with
// wb_we/wb_adr/wb_speed/wb_dat_i valid in the same cycle. The controller
// captures the request once, answers with wb_ack high for exactly one cycle
// (wb_err qualifies that same cycle as a timeout, wb_dat_o is valid in it for
// reads), and then ignores the bus until wb_stb has been seen low. Dropping
// wb_stb before the ack abandons the request with no ack.
// -----------------------------------------------------------------------------
interface podule_bus_ctrl_if;

  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [13:0] wb_adr;
  logic [1:0]  wb_speed;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack;
  logic        wb_err;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_speed, wb_dat_i,
    input  wb_dat_o, wb_ack, wb_err
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_speed, wb_dat_i,
    output wb_dat_o, wb_ack, wb_err
  );

endinterface

// File: rtl/podule_bus_ctrl_tick_timer.sv
// -----------------------------------------------------------------------------
// podule_tick_timer
// Counts clk8m_en ticks for the podule cycle currently in progress.
//   clk, rst    : clock and synchronous active-high reset
//   clk8m_en    : 8 MHz tick enable, advances the counter
//   clk2m_en    : 2 MHz tick enable, start alignment for sync cycles
//   clear       : zero the counter (takes priority over counting)
//   count_en    : counter advances on clk8m_en while high
//   speed       : latched cycle speed, selects the strobe length
//   setup_go    : setup may end this cycle (always, or on clk2m_en for sync)
//   tick_done   : this tick brings the count to the strobe length
//   timeout     : this tick brings the count to TIMEOUT_TICKS
// -----------------------------------------------------------------------------
module podule_tick_timer
  import podule_pkg::*;
#(
  parameter int SLOW_TICKS    = 12,
  parameter int MED_TICKS     = 8,
  parameter int FAST_TICKS    = 4,
  parameter int SYNC_TICKS    = 4,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clk8m_en,
  input  logic   clk2m_en,
  input  logic   clear,
  input  logic   count_en,
  input  speed_e speed,
  output logic   setup_go,
  output logic   tick_done,
  output logic   timeout
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_TICKS);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] target;
  logic             tick;

  assign tick      = count_en & clk8m_en;
  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    target = CNT_W'(SLOW_TICKS);
    case (speed)
      SPD_SLOW: target = CNT_W'(SLOW_TICKS);
      SPD_MED:  target = CNT_W'(MED_TICKS);
      SPD_FAST: target = CNT_W'(FAST_TICKS);
      SPD_SYNC: target = CNT_W'(SYNC_TICKS);
      default:  target = CNT_W'(SLOW_TICKS);
    endcase
  end

  // Sync cycles only start their strobe on a 2 MHz boundary; the others
  // leave setup after its single cycle.
  assign setup_go = (speed != SPD_SYNC) | clk2m_en;

  // Both compares look at the value the counter is about to take, so the
  // FSM changes state on the same edge as the terminal tick.
  assign tick_done = tick & (count_inc >= target);
  assign timeout   = tick & (count_inc >= TO_LIM);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick && (count_q < TO_LIM)) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/podule_bus_ctrl.sv
// -----------------------------------------------------------------------------
// podule_bus_ctrl
// Sequences CPU accesses to the four expansion podule slots with IOC cycle
// timing. One slot is strobed per access and one 16-bit result is returned
// with a single-cycle ack.
//   clkcpu, rst_i       : clock and synchronous active-high reset
//   clk8m_en, clk2m_en  : IOC tick enables
//   wb                  : CPU wishbone bundle (slave side)
//   slot_sel            : one-hot slot strobe
//   slot_we             : write qualifier, valid while the access is live
//   slot_adr/slot_wdata : latched slot offset and write data
//   slot_rdata          : slot n read data on bits [16n+15:16n]
//   slot_rdy            : slot n ready
//   slot_present        : slot n populated
//   dbg_state           : current FSM state
// -----------------------------------------------------------------------------
module podule_bus_ctrl
  import podule_pkg::*;
#(
  parameter int SLOW_TICKS    = 12,
  parameter int MED_TICKS     = 8,
  parameter int FAST_TICKS    = 4,
  parameter int SYNC_TICKS    = 4,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic                  clkcpu,
  input  logic                  rst_i,
  input  logic                  clk8m_en,
  input  logic                  clk2m_en,
  podule_bus_ctrl_if.slave      wb,
  output logic [SLOT_COUNT-1:0] slot_sel,
  output logic                  slot_we,
  output logic [11:0]           slot_adr,
  output logic [15:0]           slot_wdata,
  input  logic [63:0]           slot_rdata,
  input  logic [SLOT_COUNT-1:0] slot_rdy,
  input  logic [SLOT_COUNT-1:0] slot_present,
  output state_e                dbg_state
);

  state_e                state_q,    state_d;
  logic [1:0]            slot_q,     slot_d;
  speed_e                speed_q,    speed_d;
  logic                  we_q,       we_d;
  logic [11:0]           adr_q,      adr_d;
  logic [15:0]           wdata_q,    wdata_d;
  logic [15:0]           dat_q,      dat_d;
  logic                  ack_q,      ack_d;
  logic                  err_q,      err_d;
  logic [SLOT_COUNT-1:0] slot_sel_q, slot_sel_d;
  logic                  slot_we_q,  slot_we_d;

  logic timer_clear;
  logic timer_en;
  logic setup_go;
  logic tick_done;
  logic timeout;
  logic live_d;
  logic strobing_d;

  // The counter only runs while the slot is strobed. It restarts when the
  // strobe phase ends so the hold phase measures its own timeout.
  assign timer_en    = (state_q == STROBE) || (state_q == HOLD);
  assign timer_clear = !timer_en || ((state_q == STROBE) && tick_done);

  podule_tick_timer #(
    .SLOW_TICKS   (SLOW_TICKS),
    .MED_TICKS    (MED_TICKS),
    .FAST_TICKS   (FAST_TICKS),
    .SYNC_TICKS   (SYNC_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timer (
    .clk      (clkcpu),
    .rst      (rst_i),
    .clk8m_en (clk8m_en),
    .clk2m_en (clk2m_en),
    .clear    (timer_clear),
    .count_en (timer_en),
    .speed    (speed_q),
    .setup_go (setup_go),
    .tick_done(tick_done),
    .timeout  (timeout)
  );

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    speed_d    = speed_q;
    we_d       = we_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    dat_d      = dat_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    live_d     = 1'b0;
    strobing_d = 1'b0;
    slot_sel_d = '0;
    slot_we_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (wb.wb_cyc && wb.wb_stb) begin
          // Every request field is captured here; later bus changes are
          // ignored for the rest of the access.
          slot_d  = wb.wb_adr[13:12];
          adr_d   = wb.wb_adr[11:0];
          we_d    = wb.wb_we;
          wdata_d = wb.wb_dat_i;
          speed_d = speed_e'(wb.wb_speed);
          if (slot_present[wb.wb_adr[13:12]]) begin
            state_d = SETUP;
          end else begin
            // Empty slot: answer at once with open-bus data, never strobe.
            state_d = ACK;
            ack_d   = 1'b1;
            if (!wb.wb_we) begin
              dat_d = 16'hFFFF;
            end
          end
        end
      end

      SETUP: begin
        if (!wb.wb_stb) begin
          state_d = IDLE;
        end else if (setup_go) begin
          state_d = STROBE;
        end
      end

      STROBE: begin
        if (!wb.wb_stb) begin
          state_d = IDLE;
        end else if (tick_done) begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (!wb.wb_stb) begin
          state_d = IDLE;
        end else if (slot_rdy[slot_q]) begin
          state_d = ACK;
          ack_d   = 1'b1;
          if (!we_q) begin
            dat_d = slot_lane(slot_rdata, slot_q);
          end
        end else if (timeout) begin
          state_d = ACK;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          dat_d   = 16'hFFFF;
        end
      end

      ACK: begin
        state_d = RELEASE;
      end

      RELEASE: begin
        // Holding the strobe after the ack must not start a second access.
        if (!wb.wb_stb) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Slot-side outputs follow the next state so they are registered and
    // line up with it: slot_sel rises entering STROBE and falls entering ACK
    // or on an abort.
    live_d     = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    strobing_d = (state_d == STROBE) || (state_d == HOLD);
    slot_sel_d = strobing_d ? slot_onehot(slot_d) : '0;
    slot_we_d  = live_d & we_d;
  end

  always_ff @(posedge clkcpu) begin
    if (rst_i) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      speed_q    <= SPD_SLOW;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      dat_q      <= 16'hFFFF;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      slot_sel_q <= '0;
      slot_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      speed_q    <= speed_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      dat_q      <= dat_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      slot_sel_q <= slot_sel_d;
      slot_we_q  <= slot_we_d;
    end
  end

  assign wb.wb_dat_o = dat_q;
  assign wb.wb_ack   = ack_q;
  assign wb.wb_err   = err_q;
  assign slot_sel    = slot_sel_q;
  assign slot_we     = slot_we_q;
  assign slot_adr    = adr_q;
  assign slot_wdata  = wdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_podule_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_podule_bus_ctrl
// Directed bench for podule_bus_ctrl. Requests are issued so that the edge
// sampling the strobe is an 8 MHz tick edge (ticks every 4 clocks). Latency
// is counted in clock edges from strobe assertion up to and including the
// first edge that samples ack high.
// -----------------------------------------------------------------------------
module tb_podule_bus_ctrl;
  import podule_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clkcpu   = 1'b0;
  logic        rst_i    = 1'b1;
  logic        clk8m_en = 1'b0;
  logic        clk2m_en = 1'b0;
  logic [3:0]  slot_sel;
  logic        slot_we;
  logic [11:0] slot_adr;
  logic [15:0] slot_wdata;
  logic [63:0] slot_rdata;
  logic [3:0]  slot_rdy;
  logic [3:0]  slot_present;
  state_e      dbg_state;

  int unsigned cyc = 0;

  always #5 clkcpu = ~clkcpu;
  always @(posedge clkcpu) cyc <= cyc + 1;

  // 8 MHz enable: high on every edge that brings cyc to a multiple of 4.
  always @(negedge clkcpu) clk8m_en = (((cyc + 1) % 4) == 0);

  podule_bus_ctrl_if bus();

  podule_bus_ctrl dut (
    .clkcpu      (clkcpu),
    .rst_i       (rst_i),
    .clk8m_en    (clk8m_en),
    .clk2m_en    (clk2m_en),
    .wb          (bus),
    .slot_sel    (slot_sel),
    .slot_we     (slot_we),
    .slot_adr    (slot_adr),
    .slot_wdata  (slot_wdata),
    .slot_rdata  (slot_rdata),
    .slot_rdy    (slot_rdy),
    .slot_present(slot_present),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry: {ack cycle [48:17], err [16], data [15:0]}
  logic [48:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack pops one expected response.
  always @(negedge clkcpu) begin
    logic [48:0] e;
    if (bus.wb_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=ack expected=no_ack (cyc %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("ack_data", 32'(bus.wb_dat_o), 32'(e[15:0]));
        chk("ack_err", 32'(bus.wb_err), 32'(e[16]));
        chk("ack_cycle", cyc, e[48:17]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic release_bus();
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    bus.wb_we  = 1'b0;
  endtask

  // Present a request at a negedge whose following edge is a tick edge.
  task automatic start_req(input logic [1:0] slot, input logic [11:0] off,
                           input logic [1:0] spd, input logic we,
                           input logic [15:0] wd, output int unsigned c0);
    do @(negedge clkcpu); while (((cyc + 1) % 4) != 0);
    bus.wb_adr   = {slot, off};
    bus.wb_speed = spd;
    bus.wb_we    = we;
    bus.wb_dat_i = wd;
    bus.wb_cyc   = 1'b1;
    bus.wb_stb   = 1'b1;
    c0 = cyc;
  endtask

  task automatic run_access(input string name, input logic [1:0] slot,
                            input logic [11:0] off, input logic [1:0] spd,
                            input logic we, input logic [15:0] wd,
                            input logic [15:0] exp_dat, input logic exp_err,
                            input int exp_lat, input int exp_sel,
                            input int exp_rise, input int sync_dly);
    int unsigned c0;
    int          sel_cnt = 0;
    int          rise    = 0;
    logic        bad_sel = 1'b0;
    logic        bad_bus = 1'b0;
    logic        got_ack = 1'b0;
    logic [31:0] ack_cyc;
    start_req(slot, off, spd, we, wd, c0);
    ack_cyc = c0 + exp_lat - 1;
    exp_q.push_back({ack_cyc, exp_err, exp_dat});
    for (int i = 0; i < 400; i++) begin
      @(negedge clkcpu);
      if (i == 0) begin
        // Request is latched by now; disturb the bus to prove it.
        bus.wb_adr   = ~bus.wb_adr;
        bus.wb_dat_i = ~bus.wb_dat_i;
        bus.wb_speed = ~bus.wb_speed;
        bus.wb_we    = ~bus.wb_we;
      end
      if (slot_sel != 4'b0000) begin
        sel_cnt++;
        if (rise == 0) rise = cyc - c0;
        if (slot_sel != (4'b0001 << slot)) bad_sel = 1'b1;
        if (slot_we !== we || slot_wdata !== wd || slot_adr !== off) bad_bus = 1'b1;
      end
      clk2m_en = (sync_dly != 0) && (cyc == c0 + sync_dly - 1);
      if (bus.wb_ack === 1'b1) begin
        got_ack = 1'b1;
        break;
      end
    end
    clk2m_en = 1'b0;
    chk({name, "_ack_seen"}, 32'(got_ack), 32'd1);
    chk({name, "_sel_cycles"}, sel_cnt, exp_sel);
    chk({name, "_sel_rise"}, rise, exp_rise);
    chk({name, "_sel_onehot_bad"}, 32'(bad_sel), 32'd0);
    chk({name, "_slot_bus_bad"}, 32'(bad_bus), 32'd0);
    // Keep the strobe held: no further ack, parked in RELEASE.
    repeat (3) @(negedge clkcpu);
    chk({name, "_release_state"}, 32'(dbg_state), 32'(RELEASE));
    chk({name, "_release_sel"}, 32'(slot_sel), 32'd0);
    release_bus();
    repeat (2) @(negedge clkcpu);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned c0;
    bus.wb_cyc   = 1'b0;
    bus.wb_stb   = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_adr   = '0;
    bus.wb_speed = '0;
    bus.wb_dat_i = '0;
    slot_rdata   = {16'hBEEF, 16'h1357, 16'h5AA5, 16'hA55A};
    slot_rdy     = 4'hF;
    slot_present = 4'hF;

    repeat (3) @(negedge clkcpu);
    chk("rst_dat_o", 32'(bus.wb_dat_o), 32'h0000FFFF);
    chk("rst_ack", 32'(bus.wb_ack), 32'd0);
    chk("rst_err", 32'(bus.wb_err), 32'd0);
    chk("rst_sel", 32'(slot_sel), 32'd0);
    chk("rst_we", 32'(slot_we), 32'd0);
    chk("rst_adr", 32'(slot_adr), 32'd0);
    chk("rst_wdata", 32'(slot_wdata), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_i = 1'b0;
    repeat (2) @(negedge clkcpu);

    // Fast read slot 0: 4 ticks, ack 19 edges after strobe.
    run_access("fast_rd", 2'd0, 12'h010, SPD_FAST, 1'b0, 16'h0000,
               16'hA55A, 1'b0, 19, 16, 2, 0);
    // Slow write slot 2: 12 ticks, read data keeps its previous value.
    run_access("slow_wr", 2'd2, 12'h123, SPD_SLOW, 1'b1, 16'h1234,
               16'hA55A, 1'b0, 51, 48, 2, 0);
    // Absent slot 3: immediate open-bus answer, no strobe.
    slot_present = 4'b0001;
    run_access("absent_rd", 2'd3, 12'h0AB, SPD_FAST, 1'b0, 16'h0000,
               16'hFFFF, 1'b0, 2, 0, 0, 0);
    slot_present = 4'hF;
    // Medium read slot 1 never ready: 8 + 64 ticks then error.
    slot_rdy = 4'b1101;
    run_access("timeout_rd", 2'd1, 12'h044, SPD_MED, 1'b0, 16'h0000,
               16'hFFFF, 1'b1, 290, 287, 2, 0);
    slot_rdy = 4'hF;
    // Sync read: clk2m_en sampled 7 edges after strobe, strobe spans 4 ticks.
    run_access("sync_rd", 2'd0, 12'h200, SPD_SYNC, 1'b0, 16'h0000,
               16'hA55A, 1'b0, 23, 15, 7, 7);

    // Reset in the middle of a strobe phase.
    start_req(2'd0, 12'h001, SPD_FAST, 1'b0, 16'h0000, c0);
    repeat (6) @(negedge clkcpu);
    chk("mid_rst_pre_state", 32'(dbg_state), 32'(STROBE));
    chk("mid_rst_pre_sel", 32'(slot_sel), 32'd1);
    rst_i = 1'b1;
    release_bus();
    @(negedge clkcpu);
    chk("mid_rst_sel", 32'(slot_sel), 32'd0);
    chk("mid_rst_ack", 32'(bus.wb_ack), 32'd0);
    chk("mid_rst_dat_o", 32'(bus.wb_dat_o), 32'h0000FFFF);
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    rst_i = 1'b0;
    repeat (4) @(negedge clkcpu);
    run_access("post_rst_rd", 2'd3, 12'h0F0, SPD_FAST, 1'b0, 16'h0000,
               16'hBEEF, 1'b0, 19, 16, 2, 0);

    // Strobe dropped while waiting in HOLD on a not-ready slot.
    slot_rdy = 4'b1101;
    start_req(2'd1, 12'h055, SPD_FAST, 1'b0, 16'h0000, c0);
    repeat (20) @(negedge clkcpu);
    chk("abort_pre_state", 32'(dbg_state), 32'(HOLD));
    chk("abort_pre_sel", 32'(slot_sel), 32'd2);
    release_bus();
    @(negedge clkcpu);
    chk("abort_sel", 32'(slot_sel), 32'd0);
    chk("abort_ack", 32'(bus.wb_ack), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    repeat (4) @(negedge clkcpu);
    slot_rdy = 4'hF;
    run_access("post_abort_rd", 2'd1, 12'h066, SPD_MED, 1'b0, 16'h0000,
               16'h5AA5, 1'b0, 35, 32, 2, 0);

    repeat (10) @(negedge clkcpu);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
